// File: rtl/sf2_uart_pkg.sv
// Shared definitions for the SmartFusion2 UART receiver and the transmitter planned to sit beside it.
package sf2_uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_rx_state_t;

    // Clocks per oversample tick, rounded to nearest ($rtoi truncates after the +0.5).
    function automatic int uart_divisor(real clk, real baud);
        return $rtoi(clk / (baud * 16.0) + 0.5);
    endfunction

endpackage

// File: rtl/sf2_uart_baud_tick.sv
// Oversample tick generator: strobes tick once every DIV clocks; clear restarts the phase.
module sf2_uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk_50mhz,
    input  logic rst_50mhz,
    input  logic clear,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk_50mhz) begin
        if (rst_50mhz || clear) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST) && !clear;

endmodule

// File: rtl/sf2_uart_rx.sv
// 16x oversampling UART receiver (8N1) with a one-entry valid/ready holding register.
// Define SF2_UART_RX_PARITY_EN to receive 8E1 frames and report parity mismatches on rx_perr.
module sf2_uart_rx
    import sf2_uart_pkg::*;
#(
    parameter real CLK_FREQUENCY = 50.0e6,
    parameter real BAUD_RATE     = 115200.0
) (
    input  logic       clk_50mhz,
    input  logic       rst_50mhz,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_ferr,
    output logic       rx_perr,
    output logic       rx_overrun
);
    localparam int DIV = uart_divisor(CLK_FREQUENCY, BAUD_RATE);
    localparam int SYNC_STAGES = 2;
    localparam logic [3:0] OS_MID  = 4'(MID_SAMPLE);
    localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);

    if (DIV < 1) begin : g_bad_div
        $error("sf2_uart_rx: clock too slow for requested baud rate (divisor < 1)");
    end

    logic sync_reg [SYNC_STAGES];
    logic rxd_s;
    logic rxd_prev_reg;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        logic stage_in;
        if (gi == 0) begin : g_first
            assign stage_in = uart_rxd;
        end else begin : g_next
            assign stage_in = sync_reg[gi-1];
        end
        always_ff @(posedge clk_50mhz) begin
            if (rst_50mhz) sync_reg[gi] <= 1'b1;
            else           sync_reg[gi] <= stage_in;
        end
    end

    assign rxd_s = sync_reg[SYNC_STAGES-1];

    logic clear_tick;
    logic tick;

    sf2_uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk_50mhz (clk_50mhz),
        .rst_50mhz (rst_50mhz),
        .clear     (clear_tick),
        .tick      (tick)
    );

    uart_rx_state_t state_reg, state_next;
    logic [3:0] os_reg, os_next;
    logic [2:0] bit_reg, bit_next;
    logic [7:0] shift_reg, shift_next;
    logic       deliver_reg, deliver_next;
    logic       frame_ferr_reg, frame_ferr_next;
    logic       frame_perr_reg, frame_perr_next;

    always_ff @(posedge clk_50mhz) begin
        if (rst_50mhz) begin
            state_reg      <= ST_IDLE;
            rxd_prev_reg   <= 1'b1;
            os_reg         <= '0;
            bit_reg        <= '0;
            shift_reg      <= '0;
            deliver_reg    <= 1'b0;
            frame_ferr_reg <= 1'b0;
            frame_perr_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rxd_prev_reg   <= rxd_s;
            os_reg         <= os_next;
            bit_reg        <= bit_next;
            shift_reg      <= shift_next;
            deliver_reg    <= deliver_next;
            frame_ferr_reg <= frame_ferr_next;
            frame_perr_reg <= frame_perr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        os_next         = os_reg;
        bit_next        = bit_reg;
        shift_next      = shift_reg;
        deliver_next    = 1'b0;
        frame_ferr_next = frame_ferr_reg;
        frame_perr_next = frame_perr_reg;
        clear_tick      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Edge-triggered so a held-low (break) line cannot restart a frame.
                if (rxd_prev_reg && !rxd_s) begin
                    clear_tick = 1'b1;
                    os_next    = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (os_reg == OS_MID) begin
                        os_next         = '0;
                        bit_next        = '0;
                        frame_perr_next = 1'b0;
                        state_next      = rxd_s ? ST_IDLE : ST_DATA;
                    end else begin
                        os_next = os_reg + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    os_next = os_reg + 1'b1;
                    if (os_reg == OS_LAST) begin
                        shift_next = {rxd_s, shift_reg[7:1]};
                        bit_next   = bit_reg + 1'b1;
                        if (bit_reg == 3'd7) begin
`ifdef SF2_UART_RX_PARITY_EN
                            state_next = ST_PARITY;
`else
                            state_next = ST_STOP;
`endif
                        end
                    end
                end
            end
`ifdef SF2_UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    os_next = os_reg + 1'b1;
                    if (os_reg == OS_LAST) begin
                        frame_perr_next = ^{shift_reg, rxd_s};
                        state_next      = ST_STOP;
                    end
                end
            end
`endif
            ST_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (tick) begin
                    os_next = os_reg + 1'b1;
                    if (os_reg == OS_LAST) begin
                        frame_ferr_next = !rxd_s;
                        deliver_next    = 1'b1;
                        state_next      = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;
    logic       rx_ferr_reg;
    logic       rx_perr_reg;
    logic       rx_overrun_reg;

    always_ff @(posedge clk_50mhz) begin
        if (rst_50mhz) begin
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            rx_ferr_reg    <= 1'b0;
            rx_perr_reg    <= 1'b0;
            rx_overrun_reg <= 1'b0;
        end else begin
            rx_overrun_reg <= 1'b0;
            if (deliver_reg && (!rx_valid_reg || rx_ready)) begin
                rx_data_reg  <= shift_reg;
                rx_ferr_reg  <= frame_ferr_reg;
                rx_perr_reg  <= frame_perr_reg;
                rx_valid_reg <= 1'b1;
            end else begin
                if (deliver_reg) rx_overrun_reg <= 1'b1;
                if (rx_valid_reg && rx_ready) rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign rx_ferr    = rx_ferr_reg;
    assign rx_overrun = rx_overrun_reg;
`ifdef SF2_UART_RX_PARITY_EN
    assign rx_perr    = rx_perr_reg;
`else
    assign rx_perr    = 1'b0;
`endif

endmodule

// File: tb/tb_sf2_uart_rx.sv
// Directed bench for sf2_uart_rx: fast instance (16-clock bit) plus a default-rate latency instance.
module tb_sf2_uart_rx;
    localparam int BIT_CLKS = 16;
    localparam int BIT_DEF  = 432;
`ifdef SF2_UART_RX_PARITY_EN
    localparam int LAT_FAST = 172;
    localparam int LAT_DEF  = 4540;
`else
    localparam int LAT_FAST = 156;
    localparam int LAT_DEF  = 4108;
`endif

    logic       clk_50mhz = 1'b0;
    logic       rst_50mhz = 1'b1;
    logic       uart_rxd  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready  = 1'b1;
    logic       rx_ferr;
    logic       rx_perr;
    logic       rx_overrun;

    logic       rxd_def   = 1'b1;
    logic [7:0] data_def;
    logic       valid_def;
    logic       ferr_def;
    logic       perr_def;
    logic       overrun_def;

    always #10 clk_50mhz = ~clk_50mhz;

    sf2_uart_rx #(.CLK_FREQUENCY(50.0e6), .BAUD_RATE(3.125e6)) u_dut (
        .clk_50mhz (clk_50mhz), .rst_50mhz (rst_50mhz), .uart_rxd (uart_rxd),
        .rx_data (rx_data), .rx_valid (rx_valid), .rx_ready (rx_ready),
        .rx_ferr (rx_ferr), .rx_perr (rx_perr), .rx_overrun (rx_overrun)
    );

    sf2_uart_rx u_dut_def (
        .clk_50mhz (clk_50mhz), .rst_50mhz (rst_50mhz), .uart_rxd (rxd_def),
        .rx_data (data_def), .rx_valid (valid_def), .rx_ready (1'b1),
        .rx_ferr (ferr_def), .rx_perr (perr_def), .rx_overrun (overrun_def)
    );

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int fall_cycle = 0;

    int hs_cnt = 0, ovr_cnt = 0, rise_cycle = 0, valid_hi = 0;
    logic [7:0] hs_data = '0;
    logic hs_ferr = 1'b0, hs_perr = 1'b0, valid_d = 1'b0;
    int def_cnt = 0, def_rise = 0;
    logic [7:0] def_data = '0;
    logic def_d = 1'b0;

    always @(posedge clk_50mhz) cycle <= cycle + 1;

    always @(negedge clk_50mhz) begin
        if (rx_valid && rx_ready) begin
            hs_cnt  = hs_cnt + 1;
            hs_data = rx_data;
            hs_ferr = rx_ferr;
            hs_perr = rx_perr;
        end
        if (rx_valid) valid_hi = valid_hi + 1;
        if (rx_overrun) ovr_cnt = ovr_cnt + 1;
        if (rx_valid && !valid_d) rise_cycle = cycle;
        valid_d = rx_valid;
        if (valid_def) begin
            def_cnt  = def_cnt + 1;
            def_data = data_def;
        end
        if (valid_def && !def_d) def_rise = cycle;
        def_d = valid_def;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_50mhz);
    endtask

    // rst_at >= 0 asserts reset halfway through that data bit and holds it to frame end.
    task automatic send_frame(input logic [7:0] data, input logic stop_val,
                              input logic bad_par, input int rst_at);
        uart_rxd   = 1'b0;
        fall_cycle = cycle;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = data[i];
            if (i == rst_at) begin
                wait_clks(BIT_CLKS / 2);
                rst_50mhz = 1'b1;
                wait_clks(BIT_CLKS / 2);
            end else begin
                wait_clks(BIT_CLKS);
            end
        end
`ifdef SF2_UART_RX_PARITY_EN
        uart_rxd = (^data) ^ bad_par;
        wait_clks(BIT_CLKS);
`else
        if (bad_par) uart_rxd = 1'b1;
`endif
        uart_rxd = stop_val;
        wait_clks(BIT_CLKS);
        uart_rxd = 1'b1;
        if (rst_at >= 0) rst_50mhz = 1'b0;
    endtask

    int base, vbase;
    logic [9:0] frame_def;

    initial begin
        wait_clks(3);
        check_eq("reset_data", {24'd0, rx_data}, 32'h00);
        check_eq("reset_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("reset_ferr", {31'd0, rx_ferr}, 32'd0);
        check_eq("reset_perr", {31'd0, rx_perr}, 32'd0);
        check_eq("reset_overrun", {31'd0, rx_overrun}, 32'd0);
        rst_50mhz = 1'b0;
        wait_clks(5);

        // Single byte, consumer always ready.
        base = hs_cnt; vbase = valid_hi;
        send_frame(8'h55, 1'b1, 1'b0, -1);
        wait_clks(20);
        check_eq("b55_count", hs_cnt - base, 32'd1);
        check_eq("b55_data", {24'd0, hs_data}, 32'h55);
        check_eq("b55_ferr", {31'd0, hs_ferr}, 32'd0);
        check_eq("b55_perr", {31'd0, hs_perr}, 32'd0);
        check_eq("b55_latency", rise_cycle - fall_cycle, LAT_FAST);
        check_eq("b55_valid_width", valid_hi - vbase, 32'd1);

        // Back-to-back with consumer stalled: second frame overruns.
        rx_ready = 1'b0;
        base = hs_cnt; vbase = ovr_cnt;
        send_frame(8'hA3, 1'b1, 1'b0, -1);
        send_frame(8'h0F, 1'b1, 1'b0, -1);
        wait_clks(20);
        check_eq("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
        check_eq("ovr_data_held", {24'd0, rx_data}, 32'hA3);
        check_eq("ovr_pulses", ovr_cnt - vbase, 32'd1);
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
        wait_clks(5);
        check_eq("ovr_accepted", hs_cnt - base, 32'd1);
        check_eq("ovr_accept_data", {24'd0, hs_data}, 32'hA3);
        check_eq("ovr_valid_clear", {31'd0, rx_valid}, 32'd0);
        rx_ready = 1'b1;
        wait_clks(20);
        check_eq("ovr_0f_dropped", hs_cnt - base, 32'd1);

        // Short low glitch is rejected as a false start.
        base = hs_cnt;
        uart_rxd = 1'b0;
        wait_clks(5);
        uart_rxd = 1'b1;
        wait_clks(30);
        check_eq("glitch_no_byte", hs_cnt - base, 32'd0);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        wait_clks(20);
        check_eq("glitch_then_count", hs_cnt - base, 32'd1);
        check_eq("glitch_then_data", {24'd0, hs_data}, 32'h7E);

        // Framing error followed by a long break.
        base = hs_cnt;
        send_frame(8'hC4, 1'b0, 1'b0, -1);
        uart_rxd = 1'b0;
        wait_clks(40 * BIT_CLKS);
        check_eq("break_count", hs_cnt - base, 32'd1);
        check_eq("break_data", {24'd0, hs_data}, 32'hC4);
        check_eq("break_ferr", {31'd0, hs_ferr}, 32'd1);
        uart_rxd = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check_eq("break_release_quiet", hs_cnt - base, 32'd1);
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        wait_clks(20);
        check_eq("after_break_data", {24'd0, hs_data}, 32'h5A);
        check_eq("after_break_ferr", {31'd0, hs_ferr}, 32'd0);

        // Reset mid-frame abandons the byte.
        base = hs_cnt;
        send_frame(8'h99, 1'b1, 1'b0, 4);
        wait_clks(20);
        check_eq("rst_mid_no_byte", hs_cnt - base, 32'd0);
        send_frame(8'h12, 1'b1, 1'b0, -1);
        wait_clks(20);
        check_eq("rst_then_count", hs_cnt - base, 32'd1);
        check_eq("rst_then_data", {24'd0, hs_data}, 32'h12);

`ifdef SF2_UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b0, -1);
        wait_clks(20);
        check_eq("par_good_perr", {31'd0, hs_perr}, 32'd0);
        send_frame(8'h03, 1'b1, 1'b1, -1);
        wait_clks(20);
        check_eq("par_bad_perr", {31'd0, hs_perr}, 32'd1);
        check_eq("par_bad_data", {24'd0, hs_data}, 32'h03);
`endif

        // Default 115200 baud instance: latency from pad fall to rx_valid.
        frame_def = {1'b1, 8'h41, 1'b0};
        fall_cycle = cycle;
        for (int i = 0; i < 10; i++) begin
            rxd_def = frame_def[i];
            wait_clks(BIT_DEF);
`ifdef SF2_UART_RX_PARITY_EN
            if (i == 8) begin
                rxd_def = ^frame_def[8:1];
                wait_clks(BIT_DEF);
            end
`endif
        end
        rxd_def = 1'b1;
        wait_clks(20);
        check_eq("def_count", def_cnt, 32'd1);
        check_eq("def_data", {24'd0, def_data}, 32'h41);
        check_eq("def_latency",
                 ((def_rise - fall_cycle) >= LAT_DEF - 1 && (def_rise - fall_cycle) <= LAT_DEF + 1)
                     ? LAT_DEF : def_rise - fall_cycle,
                 LAT_DEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
